// File: rtl/gates_pkg.sv
// Shared constants and state type for the gate-reduction blocks.
package gates_pkg;

    localparam int Y_AND  = 0;
    localparam int Y_NAND = 1;
    localparam int Y_OR   = 2;
    localparam int Y_NOR  = 3;
    localparam int Y_XOR  = 4;
    localparam int Y_XNOR = 5;
    localparam int Y_W    = 6;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/gates_reduce_word.sv
// Combinational AND/OR/XOR reduction of a single WIDTH-bit word.
module gates_reduce_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor
);

    assign red_and = &data;
    assign red_or  = |data;
    assign red_xor = ^data;

endmodule

// File: rtl/gates_reduce_stream.sv
// Accumulates AND/OR/XOR reductions over a multi-beat packet and presents
// the six results plus a saturating beat count through a registered handshake.
module gates_reduce_stream
    import gates_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Y_W-1:0]     out_y,
    output logic [COUNT_W-1:0] out_beats
);

    state_e               state_q, state_d;
    logic                 and_acc_q, and_acc_d;
    logic                 or_acc_q, or_acc_d;
    logic                 xor_acc_q, xor_acc_d;
    logic [COUNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [Y_W-1:0]       out_y_q, out_y_d;
    logic [COUNT_W-1:0]   out_beats_q, out_beats_d;

    logic                 w_and, w_or, w_xor;
    logic                 and_nxt, or_nxt, xor_nxt;
    logic [COUNT_W-1:0]   cnt_nxt;
    logic                 accept;

    gates_reduce_word #(.WIDTH(WIDTH)) u_word (
        .data    (in_data),
        .red_and (w_and),
        .red_or  (w_or),
        .red_xor (w_xor)
    );

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_y     = out_y_q;
    assign out_beats = out_beats_q;

    // Accumulator values including the beat currently offered.
    assign and_nxt = and_acc_q & w_and;
    assign or_nxt  = or_acc_q | w_or;
    assign xor_nxt = xor_acc_q ^ w_xor;
    assign cnt_nxt = (beat_cnt_q == {COUNT_W{1'b1}}) ? beat_cnt_q
                                                     : beat_cnt_q + COUNT_W'(1);

    always_comb begin
        state_d     = state_q;
        and_acc_d   = and_acc_q;
        or_acc_d    = or_acc_q;
        xor_acc_d   = xor_acc_q;
        beat_cnt_d  = beat_cnt_q;
        out_y_d     = out_y_q;
        out_beats_d = out_beats_q;

        if (state_q == HOLD && out_ready) begin
            state_d = ACCUM;
        end

        if (accept) begin
            if (in_last) begin
                out_y_d[Y_AND]  = and_nxt;
                out_y_d[Y_NAND] = ~and_nxt;
                out_y_d[Y_OR]   = or_nxt;
                out_y_d[Y_NOR]  = ~or_nxt;
                out_y_d[Y_XOR]  = xor_nxt;
                out_y_d[Y_XNOR] = ~xor_nxt;
                out_beats_d     = cnt_nxt;
                and_acc_d       = 1'b1;
                or_acc_d        = 1'b0;
                xor_acc_d       = 1'b0;
                beat_cnt_d      = '0;
                // A consume on this same edge is overridden: new result replaces old.
                state_d         = HOLD;
            end else begin
                and_acc_d  = and_nxt;
                or_acc_d   = or_nxt;
                xor_acc_d  = xor_nxt;
                beat_cnt_d = cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            and_acc_q   <= 1'b1;
            or_acc_q    <= 1'b0;
            xor_acc_q   <= 1'b0;
            beat_cnt_q  <= '0;
            out_y_q     <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            and_acc_q   <= and_acc_d;
            or_acc_q    <= or_acc_d;
            xor_acc_q   <= xor_acc_d;
            beat_cnt_q  <= beat_cnt_d;
            out_y_q     <= out_y_d;
            out_beats_q <= out_beats_d;
        end
    end

endmodule

// File: tb/tb_gates_reduce_stream.sv
// Scoreboard bench for gates_reduce_stream: directed cases plus random packets
// against a bit-list reference model.
module tb_gates_reduce_stream;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_y;
    logic [CW-1:0] out_beats;

    gates_reduce_stream #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    y;
        logic [CW-1:0] beats;
    } res_t;

    res_t         exp_q[$];
    logic [W-1:0] pkt[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    bit           rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: reduce over the flat list of every bit in the packet.
    function automatic res_t model_pkt();
        res_t r;
        bit   a, o, x;
        int   n;
        a = 1'b1; o = 1'b0; x = 1'b0;
        n = pkt.size();
        foreach (pkt[i])
            for (int b = 0; b < W; b++) begin
                a = a & pkt[i][b];
                o = o | pkt[i][b];
                x = x ^ pkt[i][b];
            end
        r.y     = {~x, x, ~o, o, ~a, a};
        r.beats = (n > 3) ? CW'(3) : CW'(n);
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            pkt.push_back(d);
            if (l) begin
                exp_q.push_back(model_pkt());
                pkt.delete();
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
    endtask

    // Monitor: compare every consumed result, and check stability under stall.
    bit            hold_prev = 1'b0;
    logic [5:0]    held_y;
    logic [CW-1:0] held_beats;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_y", 32'(out_y), 32'(held_y));
                check("stall_beats", 32'(out_beats), 32'(held_beats));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_y", 32'(out_y), 32'(e.y));
                    check("sb_beats", 32'(out_beats), 32'(e.beats));
                end
            end
            hold_prev  = out_valid && !out_ready;
            held_y     = out_y;
            held_beats = out_beats;
        end
    end

    initial begin
        int t0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(out_y), 32'd0);
        check("rst_beats", 32'(out_beats), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single full-ones beat.
        send_beat(4'b1111, 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_y", 32'(out_y), 32'b100101);
        check("t1_beats", 32'(out_beats), 32'd1);

        // Two-beat packet then a back-to-back three-beat zero packet.
        send_beat(4'b1000, 1'b0);
        send_beat(4'b0001, 1'b1);
        check("t2_y", 32'(out_y), 32'b100110);
        check("t2_beats", 32'(out_beats), 32'd2);
        t0 = cyc;
        send_beat(4'b0000, 1'b0);
        send_beat(4'b0000, 1'b0);
        send_beat(4'b0000, 1'b1);
        check("t2_no_bubble", 32'(cyc - t0), 32'd3);
        check("t2b_y", 32'(out_y), 32'b101010);
        check("t2b_beats", 32'(out_beats), 32'd3);
        @(posedge clk); #1;
        check("consume_clears_valid", 32'(out_valid), 32'd0);
        check("consume_holds_y", 32'(out_y), 32'b101010);

        // Backpressure with a stalled follow-on packet.
        out_ready = 1'b0;
        send_beat(4'b0111, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_last  = 1'b1;
        repeat (5) begin
            check("bp_y", 32'(out_y), 32'b010110);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        // Consume and last-beat accept on the same edge.
        pkt.push_back(4'b1111);
        exp_q.push_back(model_pkt());
        pkt.delete();
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("swap_valid", 32'(out_valid), 32'd1);
        check("swap_y", 32'(out_y), 32'b100101);

        // Saturating beat count.
        for (int i = 0; i < 5; i++) send_beat(W'($urandom), (i == 4));
        check("sat_beats", 32'(out_beats), 32'd3);

        // Asynchronous reset mid-packet.
        @(posedge clk); #1;
        send_beat(4'b1111, 1'b1);
        send_beat(4'b1000, 1'b0);
        send_beat(4'b0000, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_y", 32'(out_y), 32'd0);
        check("arst_beats", 32'(out_beats), 32'd0);
        pkt.delete();
        exp_q.delete();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send_beat(4'b0011, 1'b1);
        check("post_rst_y", 32'(out_y), 32'b100110);
        check("post_rst_beats", 32'(out_beats), 32'd1);

        // Random packets with random backpressure and input gaps.
        rand_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 60; p++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk); #1;
                        end
                        send_beat(W'($urandom), (b == len - 1));
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
